// File: rtl/mul_seq_pkg.sv
// Shared types and op-code predicates for the sequential multiply-accumulate block.
package mul_seq_pkg;

  // Op encodings as driven by the decode stage.
  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MLA   = 3'b001,
    OP_UMULL = 3'b100,
    OP_UMLAL = 3'b101,
    OP_SMULL = 3'b110,
    OP_SMLAL = 3'b111
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_t;

  // Map a raw op code onto a supported op; unused codes behave as MUL.
  function automatic mul_op_t decode_op(input logic [2:0] code);
    mul_op_t res;
    case (code)
      3'b001:  res = OP_MLA;
      3'b100:  res = OP_UMULL;
      3'b101:  res = OP_UMLAL;
      3'b110:  res = OP_SMULL;
      3'b111:  res = OP_SMLAL;
      default: res = OP_MUL;
    endcase
    return res;
  endfunction

  // Double-width (long) result ops.
  function automatic logic is_long(input mul_op_t op);
    return (op == OP_UMULL) || (op == OP_UMLAL) || (op == OP_SMULL) || (op == OP_SMLAL);
  endfunction

  // Ops that treat operands as two's complement.
  function automatic logic is_signed(input mul_op_t op);
    return (op == OP_SMULL) || (op == OP_SMLAL);
  endfunction

  // Ops that add an accumulator to the product.
  function automatic logic is_acc(input mul_op_t op);
    return (op == OP_MLA) || (op == OP_UMLAL) || (op == OP_SMLAL);
  endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One radix-2^RADIX_BITS iteration: multiplicand times one multiplier digit,
// shifted into place and added to the running double-width partial product.
module mul_radix_step #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int CNT_W      = 5
) (
  input  logic [WIDTH-1:0]      mcand_i,
  input  logic [RADIX_BITS-1:0] digit_i,
  input  logic [CNT_W-1:0]      iter_i,
  input  logic [2*WIDTH-1:0]    partial_i,
  output logic [2*WIDTH-1:0]    sum_o
);

  logic [2*WIDTH-1:0] mcand_ext_s;
  logic [2*WIDTH-1:0] digit_ext_s;
  logic [2*WIDTH-1:0] pp_s;

  // Form the digit partial product and accumulate it at the digit's weight.
  always_comb begin
    mcand_ext_s = {{WIDTH{1'b0}}, mcand_i};
    digit_ext_s = {{(2*WIDTH-RADIX_BITS){1'b0}}, digit_i};
    pp_s        = mcand_ext_s * digit_ext_s;
    sum_o       = partial_i + (pp_s << (RADIX_BITS * int'(iter_i)));
  end

endmodule

// File: rtl/mul_seq_block.sv
// Iterative multiply / multiply-accumulate engine with start/valid handshake.
// Signed ops multiply magnitudes and fix the sign in a single FIX cycle.
module mul_seq_block
  import mul_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int EARLY_TERM = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic             c_in,
  input  logic             v_in,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       cond_flags
);

  localparam int DIGITS = WIDTH / RADIX_BITS;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  mul_state_t         state_q, state_d;
  mul_op_t            op_q, op_dec_s;
  logic [WIDTH-1:0]   mcand_q, mplier_q, mcand_cap_s, mplier_cap_s, mplier_nxt_s;
  logic [2*WIDTH-1:0] acc_q, acc_cap_s, partial_q, partial_nxt_s, prod_s;
  logic [CNT_W-1:0]   iter_q, iter_nxt_s;
  logic               neg_q, c_q, v_q, neg_cap_s;
  logic               accept_s, calc_last_s, n_s, z_s;
  logic               ready_q, valid_q;
  logic [WIDTH-1:0]   result_lo_q, result_hi_q;
  logic [3:0]         flags_q;

  mul_radix_step #(.WIDTH(WIDTH), .RADIX_BITS(RADIX_BITS), .CNT_W(CNT_W)) u_step (
    .mcand_i   (mcand_q),
    .digit_i   (mplier_q[RADIX_BITS-1:0]),
    .iter_i    (iter_q),
    .partial_i (partial_q),
    .sum_o     (partial_nxt_s)
  );

  // Operand conditioning at acceptance: magnitudes and sign for signed ops, accumulator form.
  always_comb begin
    op_dec_s     = decode_op(op);
    accept_s     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !flush;
    mcand_cap_s  = a;
    mplier_cap_s = b;
    neg_cap_s    = 1'b0;
    if (is_signed(op_dec_s)) begin
      mcand_cap_s  = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
      mplier_cap_s = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
      neg_cap_s    = a[WIDTH-1] ^ b[WIDTH-1];
    end else begin
      neg_cap_s    = 1'b0;
    end
    if (is_long(op_dec_s)) begin
      acc_cap_s = {acc_hi, acc_lo};
    end else begin
      acc_cap_s = {{WIDTH{1'b0}}, acc_lo};
    end
  end

  // Iteration bookkeeping and exit condition for the CALC state.
  always_comb begin
    iter_nxt_s   = iter_q + {{(CNT_W-1){1'b0}}, 1'b1};
    mplier_nxt_s = mplier_q >> RADIX_BITS;
    calc_last_s  = (iter_nxt_s == CNT_W'(DIGITS)) ||
                   ((EARLY_TERM != 0) && (mplier_nxt_s == {WIDTH{1'b0}}));
  end

  // Sign fix, accumulate, truncation and flag derivation for the FIX state.
  always_comb begin
    prod_s = neg_q ? (~partial_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : partial_q;
    if (is_acc(op_q)) begin
      prod_s = prod_s + acc_q;
    end else begin
      prod_s = prod_s;
    end
    if (!is_long(op_q)) begin
      prod_s[2*WIDTH-1:WIDTH] = {WIDTH{1'b0}};
      n_s = prod_s[WIDTH-1];
    end else begin
      n_s = prod_s[2*WIDTH-1];
    end
    z_s = (prod_s == {(2*WIDTH){1'b0}});
  end

  // Next-state logic; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_CALC : ST_IDLE;
      ST_CALC: state_d = calc_last_s ? ST_FIX : ST_CALC;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      valid_q <= (state_d == ST_DONE);
    end
  end

  // Operand capture on acceptance and per-digit iteration in CALC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_MUL;
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      partial_q <= {(2*WIDTH){1'b0}};
      iter_q    <= {CNT_W{1'b0}};
      neg_q     <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
    end else if (accept_s) begin
      op_q      <= op_dec_s;
      mcand_q   <= mcand_cap_s;
      mplier_q  <= mplier_cap_s;
      acc_q     <= acc_cap_s;
      partial_q <= {(2*WIDTH){1'b0}};
      iter_q    <= {CNT_W{1'b0}};
      neg_q     <= neg_cap_s;
      c_q       <= c_in;
      v_q       <= v_in;
    end else if (state_q == ST_CALC) begin
      partial_q <= partial_nxt_s;
      mplier_q  <= mplier_nxt_s;
      iter_q    <= iter_nxt_s;
    end
  end

  // Result and flag registers update only on the FIX to DONE transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_lo_q <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
    end else if ((state_q == ST_FIX) && !flush) begin
      result_lo_q <= prod_s[WIDTH-1:0];
      result_hi_q <= prod_s[2*WIDTH-1:WIDTH];
      flags_q     <= {n_s, z_s, c_q, v_q};
    end
  end

  assign ready      = ready_q;
  assign valid      = valid_q;
  assign result_lo  = result_lo_q;
  assign result_hi  = result_hi_q;
  assign cond_flags = flags_q;

endmodule

// File: tb/tb_mul_seq_block.sv
// Directed bench for mul_seq_block: two instances (early termination on/off)
// share the same stimulus; expected results and latencies are hand-computed.
module tb_mul_seq_block;

  logic        clk = 1'b0;
  logic        reset_n, start, flush, c_in, v_in;
  logic [2:0]  op;
  logic [31:0] a, b, acc_lo, acc_hi;

  logic        ready_et, valid_et, ready_ne, valid_ne;
  logic [31:0] rlo_et, rhi_et, rlo_ne, rhi_ne;
  logic [3:0]  fl_et, fl_ne;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_seq_block #(.WIDTH(32), .RADIX_BITS(2), .EARLY_TERM(1)) dut_et (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .acc_lo(acc_lo), .acc_hi(acc_hi), .c_in(c_in), .v_in(v_in),
    .ready(ready_et), .valid(valid_et), .result_lo(rlo_et), .result_hi(rhi_et),
    .cond_flags(fl_et)
  );

  mul_seq_block #(.WIDTH(32), .RADIX_BITS(2), .EARLY_TERM(0)) dut_ne (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .acc_lo(acc_lo), .acc_hi(acc_hi), .c_in(c_in), .v_in(v_in),
    .ready(ready_ne), .valid(valid_ne), .result_lo(rlo_ne), .result_hi(rhi_ne),
    .cond_flags(fl_ne)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one op (at the current negedge when b2b=1, else at the next one),
  // then count cycles until valid; the accept cycle is cycle 0.
  task automatic run_op(input string tag, input bit use_ne, input bit b2b,
                        input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ilo, input logic [31:0] ihi,
                        input logic ic, input logic iv, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic [3:0] exp_fl);
    int   cyc;
    logic vs;
    if (!b2b) @(negedge clk);
    op = o; a = ia; b = ib; acc_lo = ilo; acc_hi = ihi; c_in = ic; v_in = iv;
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    vs = use_ne ? valid_ne : valid_et;
    while (!vs && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      vs = use_ne ? valid_ne : valid_et;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_res"}, use_ne ? {rhi_ne, rlo_ne} : {rhi_et, rlo_et}, {exp_hi, exp_lo});
    chk({tag, "_flags"}, 64'(use_ne ? fl_ne : fl_et), 64'(exp_fl));
  endtask

  initial begin
    logic saw_valid;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000;
    a = 32'h0; b = 32'h0; acc_lo = 32'h0; acc_hi = 32'h0; c_in = 1'b0; v_in = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_et), 64'd1);
    chk("rst_valid", 64'(valid_et), 64'd0);
    chk("rst_res", {rhi_et, rlo_et}, 64'h0);
    chk("rst_flags", 64'(fl_et), 64'd0);
    chk("rst_ready_ne", 64'(ready_ne), 64'd1);
    reset_n = 1'b1;

    // UMULL full-width, no early termination: 18 cycles
    run_op("umull_ne", 1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
           1'b0, 1'b1, 18, 32'hFFFF_FFFE, 32'h0000_0001, 4'b1001);
    chk("umull_et_res", {rhi_et, rlo_et}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("valid_one_pulse", 64'(valid_ne), 64'd0);

    // Signed and accumulate ops, early termination
    run_op("smull", 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0,
           1'b1, 1'b0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 4'b1010);
    run_op("mla", 1'b0, 1'b0, 3'b001, 32'd3, 32'd5, 32'd7, 32'h0000_DEAD,
           1'b1, 1'b1, 4, 32'h0, 32'd22, 4'b0011);
    run_op("smlal", 1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0,
           1'b0, 1'b0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000);
    run_op("mul_1234", 1'b0, 1'b0, 3'b000, 32'd1234, 32'd1, 32'h0, 32'h0,
           1'b0, 1'b1, 3, 32'h0, 32'd1234, 4'b0001);

    // Flush in cycle 5 of a long op
    @(negedge clk);
    op = 3'b100; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b1; v_in = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("flush_busy", 64'(ready_et), 64'd0);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 64'(ready_et), 64'd1);
    chk("flush_valid", 64'(valid_et), 64'd0);
    chk("flush_hold_res", {rhi_et, rlo_et}, 64'd1234);
    chk("flush_hold_flags", 64'(fl_et), 64'b0001);
    run_op("mul_6x7", 1'b0, 1'b0, 3'b000, 32'd6, 32'd7, 32'h0, 32'h0,
           1'b0, 1'b0, 4, 32'h0, 32'd42, 4'b0000);

    // Zero multiplier
    run_op("mul_zero", 1'b0, 1'b0, 3'b000, 32'd5, 32'd0, 32'h0, 32'h0,
           1'b1, 1'b1, 3, 32'h0, 32'h0, 4'b0111);

    // Flush together with start in IDLE drops the start
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_ready", 64'(ready_et), 64'd1);
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      saw_valid = saw_valid | valid_et;
    end
    chk("flush_start_novalid", 64'(saw_valid), 64'd0);
    chk("flush_start_res", {rhi_et, rlo_et}, 64'h0);

    // Async reset in cycle 4 of an op
    @(negedge clk);
    op = 3'b100; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b1; v_in = 1'b1;
    start = 1'b1;
    run_op("pre_rst", 1'b0, 1'b1, 3'b001, 32'd2, 32'd2, 32'd1, 32'd0,
           1'b0, 1'b0, 3, 32'h0, 32'd5, 4'b0000);
    @(negedge clk);
    op = 3'b100; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready_et), 64'd1);
    chk("midrst_valid", 64'(valid_et), 64'd0);
    chk("midrst_res", {rhi_et, rlo_et}, 64'h0);
    chk("midrst_flags", 64'(fl_et), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back: second start issued in DONE of the first
    run_op("b2b_a", 1'b0, 1'b0, 3'b000, 32'd6, 32'd7, 32'h0, 32'h0,
           1'b0, 1'b0, 4, 32'h0, 32'd42, 4'b0000);
    run_op("b2b_b", 1'b0, 1'b1, 3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0,
           1'b0, 1'b0, 11, 32'h0000_0001, 32'h0, 4'b0000);

    // Without early termination a trivial multiplier still takes 18 cycles
    repeat (25) @(negedge clk);
    run_op("mul_1234_ne", 1'b1, 1'b0, 3'b000, 32'd1234, 32'd1, 32'h0, 32'h0,
           1'b0, 1'b0, 18, 32'h0, 32'd1234, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
